mips_ctrl_pipe: RTL and testbench
=================================

// Module: mips_ctrl_pipe
// PURPOSE
//  Pipelined MIPS main control unit. Sits in the ID stage: decodes the opcode into a
//  16-bit control word and registers it into the ID/EX stage. Adds load-use hazard
//  detection with a configurable bubble count, branch/jump flush, a global freeze
//  and illegal-opcode flagging.
// PARAMETERS
//  NB_OPCODE  6  opcode width
//  NB_REG     5  register-address width
//  LOAD_STALL 1  bubbles inserted per load-use hazard (1..3)
//  CTRL_W     16 control-word width (fixed by package, not overridable)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous, active-high reset
//  i_enable     in   1          pipeline advance; 0 freezes all state
//  i_valid      in   1          IF/ID holds a real instruction
//  i_opcode     in   NB_OPCODE  instr[31:26]
//  i_rs         in   NB_REG     instr[25:21]
//  i_rt         in   NB_REG     instr[20:16]
//  i_flush      in   1          branch/jump taken, from a later stage
//  o_ex_ctrl    out  CTRL_W     ID/EX control word (registered)
//  o_ex_rt      out  NB_REG     ID/EX rt (registered)
//  o_stall      out  1          hold PC and IF/ID (combinational)
//  o_illegal    out  1          registered 1-cycle pulse: unknown opcode decoded
// BEHAVIOUR
//  Word: [15]Jump [14]RegDst [13:12]ALUOp [11]ALUSrc [10]BNE [9]BEQ [8]MemRead
//   [7]MemWrite [6]Signed [5:4]Size(00 word,01 byte,10 half) [3:2]0 [1]RegWrite [0]MemtoReg.
//   All don't-care fields are driven to 0.
//  Decode:
//   R-type 0x00 -> 0x4002
//   LW 0x23 -> 0x0903;  LB 0x20 -> 0x0953;  LBU 0x24 -> 0x0913;  LH 0x21 -> 0x0963;  LHU 0x25 -> 0x0923
//   SW 0x2B -> 0x0880;  SB 0x28 -> 0x0890;  SH 0x29 -> 0x08A0
//   BEQ 0x04 -> 0x1200;  BNE 0x05 -> 0x1400;  J 0x02 -> 0x8000
//   ADDI/SLTI/ANDI/ORI/XORI/LUI (0x08,0x0A,0x0C,0x0D,0x0E,0x0F) -> 0x3802
//   Anything else -> 0x0000 and o_illegal = 1.
//  Reset: o_ex_ctrl=0, o_ex_rt=0, o_illegal=0, state RUN, cnt=0. o_stall=0 one cycle after reset.
//  Latency: 1 clk from i_opcode to o_ex_ctrl. !i_valid decodes as a bubble (0x0000, no illegal).
//  Hazard (RUN): haz = i_valid & o_ex_ctrl[8] & (o_ex_rt!=0) & (o_ex_rt==i_rs |
//   (o_ex_rt==i_rt & rt_is_source)). rt_is_source is 1 for R-type, store and branch.
//  FSM, evaluated only when i_enable=1. Priority: rst > !i_enable > i_flush > FSM.
//   RUN, haz=0: register decoded word.
//   RUN, haz=1: register bubble. If LOAD_STALL>1: cnt<=LOAD_STALL-1, go to STALL.
//   STALL: register bubble, cnt<=cnt-1. At cnt==1, go to RUN.
//   o_stall = (RUN & haz) | STALL.
//  i_flush: register bubble, clear cnt, go to RUN, o_illegal<=0. The flush beats a
//   simultaneous hazard.
//  i_enable=0: all registers hold, o_stall keeps its combinational value, o_illegal holds.
//  Reset mid-stall returns to RUN with bubble outputs. No residual stall.
//  o_ex_rt is registered alongside the control word; it is 0 on every bubble.
// STRUCTURE
//  Package mips_ctrl_pkg holds:
//   - opcode localparams
//   - control-word bit indices and CTRL_W
//   - size encodings
//   - state enum {RUN, STALL}
//  Sub-module mips_ctrl_decode: purely combinational opcode -> {word, illegal, rt_is_source}.
//  The top contains the hazard compare, the FSM, the counter and the ID/EX registers.
// TESTING
//  1. rst=1 for 2 clk, then LW 0x23 (valid) -> o_ex_ctrl=0x0903 on the next clk, o_stall=0.
//  2. LW rt=5, then ADD rs=5 (LOAD_STALL=1) -> o_stall=1 for 1 clk, bubble 0x0000, then 0x4002.
//  3. LOAD_STALL=3, LW rt=7, then SW rt=7 -> 3 bubbles, o_stall high for 3 clk, then 0x0880.
//  4. LW rt=0, then ADD rs=0 -> no stall. LW rt=4, then ADDI rt=4 (rt is a dest) -> no stall.
//  5. Hazard with i_flush=1 in the same clk -> bubble, o_stall=0 the next clk. Then opcode
//     0x3F -> 0x0000 and o_illegal pulses 1 clk.
//  6. Mid-STALL: i_enable=0 for 2 clk -> cnt and o_ex_ctrl frozen; then rst -> RUN, all outputs 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS main control unit.
// Holds the opcode values, control-word bit positions, memory access size
// encodings and the hazard FSM state type.
package mips_ctrl_pkg;

  localparam int unsigned CTRL_W = 16;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control-word bit positions
  localparam int unsigned B_JUMP     = 15;
  localparam int unsigned B_REGDST   = 14;
  localparam int unsigned B_ALUOP_HI = 13;
  localparam int unsigned B_ALUOP_LO = 12;
  localparam int unsigned B_ALUSRC   = 11;
  localparam int unsigned B_BNE      = 10;
  localparam int unsigned B_BEQ      = 9;
  localparam int unsigned B_MEMREAD  = 8;
  localparam int unsigned B_MEMWRITE = 7;
  localparam int unsigned B_SIGNED   = 6;
  localparam int unsigned B_SIZE_HI  = 5;
  localparam int unsigned B_SIZE_LO  = 4;
  localparam int unsigned B_REGWRITE = 1;
  localparam int unsigned B_MEMTOREG = 0;

  // ALUOp field values
  localparam logic [1:0] ALU_RTYPE  = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_IMM    = 2'b11;

  // Memory access size field values
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef enum logic {RUN, STALL} state_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode decoder.
// Ports:
//   i_opcode       opcode field instr[31:26]
//   o_word         16-bit control word (unused fields are 0)
//   o_illegal      opcode not recognised
//   o_rt_is_source rt is read as a source operand (R-type, store, branch)
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned NB_OPCODE = 6
) (
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic [CTRL_W-1:0]    o_word,
  output logic                 o_illegal,
  output logic                 o_rt_is_source
);

  function automatic logic [CTRL_W-1:0] f_load(input logic sgn, input logic [1:0] sz);
    logic [CTRL_W-1:0] w;
    w                       = '0;
    w[B_ALUSRC]             = 1'b1;
    w[B_MEMREAD]            = 1'b1;
    w[B_REGWRITE]           = 1'b1;
    w[B_MEMTOREG]           = 1'b1;
    w[B_SIGNED]             = sgn;
    w[B_SIZE_HI:B_SIZE_LO]  = sz;
    return w;
  endfunction

  function automatic logic [CTRL_W-1:0] f_store(input logic [1:0] sz);
    logic [CTRL_W-1:0] w;
    w                       = '0;
    w[B_ALUSRC]             = 1'b1;
    w[B_MEMWRITE]           = 1'b1;
    w[B_SIZE_HI:B_SIZE_LO]  = sz;
    return w;
  endfunction

  always_comb begin
    o_word         = '0;
    o_illegal      = 1'b0;
    o_rt_is_source = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_word[B_REGDST]              = 1'b1;
        o_word[B_ALUOP_HI:B_ALUOP_LO] = ALU_RTYPE;
        o_word[B_REGWRITE]            = 1'b1;
        o_rt_is_source                = 1'b1;
      end
      OP_LW:  o_word = f_load(1'b0, SZ_WORD);
      OP_LB:  o_word = f_load(1'b1, SZ_BYTE);
      OP_LBU: o_word = f_load(1'b0, SZ_BYTE);
      OP_LH:  o_word = f_load(1'b1, SZ_HALF);
      OP_LHU: o_word = f_load(1'b0, SZ_HALF);
      OP_SW: begin o_word = f_store(SZ_WORD); o_rt_is_source = 1'b1; end
      OP_SB: begin o_word = f_store(SZ_BYTE); o_rt_is_source = 1'b1; end
      OP_SH: begin o_word = f_store(SZ_HALF); o_rt_is_source = 1'b1; end
      OP_BEQ: begin
        o_word[B_ALUOP_HI:B_ALUOP_LO] = ALU_BRANCH;
        o_word[B_BEQ]                 = 1'b1;
        o_rt_is_source                = 1'b1;
      end
      OP_BNE: begin
        o_word[B_ALUOP_HI:B_ALUOP_LO] = ALU_BRANCH;
        o_word[B_BNE]                 = 1'b1;
        o_rt_is_source                = 1'b1;
      end
      OP_J: o_word[B_JUMP] = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_word[B_ALUOP_HI:B_ALUOP_LO] = ALU_IMM;
        o_word[B_ALUSRC]              = 1'b1;
        o_word[B_REGWRITE]            = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined MIPS main control unit (ID stage) with ID/EX control register,
// load-use hazard detection with LOAD_STALL bubbles, flush, freeze and
// illegal-opcode flag.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   i_enable    pipeline advance (0 freezes all state)
//   i_valid     IF/ID holds a real instruction
//   i_opcode    instr[31:26];  i_rs instr[25:21];  i_rt instr[20:16]
//   i_flush     taken branch/jump from a later stage
//   o_ex_ctrl   registered ID/EX control word
//   o_ex_rt     registered ID/EX rt (0 on bubbles)
//   o_stall     combinational hold for PC and IF/ID
//   o_illegal   registered 1-cycle pulse on unknown opcode
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned NB_OPCODE  = 6,
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_REG-1:0]    i_rs,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic                 i_flush,
  output logic [CTRL_W-1:0]    o_ex_ctrl,
  output logic [NB_REG-1:0]    o_ex_rt,
  output logic                 o_stall,
  output logic                 o_illegal
);

  logic [CTRL_W-1:0] w_word;
  logic              w_illegal;
  logic              w_rt_src;
  logic              w_haz;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [NB_REG-1:0] r_ex_rt;
  logic              r_illegal;

  mips_ctrl_decode #(.NB_OPCODE(NB_OPCODE)) u_decode (
    .i_opcode       (i_opcode),
    .o_word         (w_word),
    .o_illegal      (w_illegal),
    .o_rt_is_source (w_rt_src)
  );

  // Load in EX whose destination is read by the instruction in ID.
  assign w_haz = i_valid & r_ex_ctrl[B_MEMREAD] & (r_ex_rt != '0) &
                 ((r_ex_rt == i_rs) | ((r_ex_rt == i_rt) & w_rt_src));

  assign o_stall   = ((r_state == RUN) & w_haz) | (r_state == STALL);
  assign o_ex_ctrl = r_ex_ctrl;
  assign o_ex_rt   = r_ex_rt;
  assign o_illegal = r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_ex_ctrl <= '0;
      r_ex_rt   <= '0;
      r_illegal <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        r_state   <= RUN;
        r_cnt     <= '0;
        r_ex_ctrl <= '0;
        r_ex_rt   <= '0;
        r_illegal <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (w_haz) begin
              r_ex_ctrl <= '0;
              r_ex_rt   <= '0;
              r_illegal <= 1'b0;
              // The first bubble is issued here; STALL covers the rest.
              if (LOAD_STALL > 1) begin
                r_cnt   <= 2'(LOAD_STALL - 1);
                r_state <= STALL;
              end
            end else begin
              r_ex_ctrl <= i_valid ? w_word : '0;
              r_ex_rt   <= i_valid ? i_rt : '0;
              r_illegal <= i_valid & w_illegal;
            end
          end
          STALL: begin
            r_ex_ctrl <= '0;
            r_ex_rt   <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) r_state <= RUN;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
module tb_mips_ctrl_pipe;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        flush;

  logic [15:0] ctrl1, ctrl3;
  logic [4:0]  rt1, rt3;
  logic        stall1, stall3, ill1, ill3;

  int total = 0;
  int bad   = 0;

  mips_ctrl_pipe #(.NB_OPCODE(6), .NB_REG(5), .LOAD_STALL(1)) dut1 (
    .clk(clk), .rst(rst), .i_enable(en), .i_valid(valid), .i_opcode(op),
    .i_rs(rs), .i_rt(rt), .i_flush(flush),
    .o_ex_ctrl(ctrl1), .o_ex_rt(rt1), .o_stall(stall1), .o_illegal(ill1)
  );

  mips_ctrl_pipe #(.NB_OPCODE(6), .NB_REG(5), .LOAD_STALL(3)) dut3 (
    .clk(clk), .rst(rst), .i_enable(en), .i_valid(valid), .i_opcode(op),
    .i_rs(rs), .i_rt(rt), .i_flush(flush),
    .o_ex_ctrl(ctrl3), .o_ex_rt(rt3), .o_stall(stall3), .o_illegal(ill3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t);
    valid = v;
    op    = o;
    rs    = s;
    rt    = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  t_op  [16] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04,
                              6'h05, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [15:0] t_exp [16] = '{16'h0953, 16'h0913, 16'h0963, 16'h0923, 16'h0890, 16'h08A0,
                              16'h0880, 16'h1200, 16'h1400, 16'h8000, 16'h3802, 16'h3802,
                              16'h3802, 16'h3802, 16'h3802, 16'h3802};

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    drv(1'b0, 6'h00, 5'd0, 5'd0);
    tick(); tick();
    chk("rst_ctrl", 32'(ctrl1), 32'h0);
    chk("rst_rt", 32'(rt1), 32'h0);
    chk("rst_ill", 32'(ill1), 32'h0);
    chk("rst_stall", 32'(stall1), 32'h0);
    rst = 1'b0;

    // LW decode and latency
    drv(1'b1, 6'h23, 5'd0, 5'd5);
    #1 chk("lw_stall", 32'(stall1), 32'h0);
    tick();
    chk("lw_ctrl", 32'(ctrl1), 32'h0903);
    chk("lw_rt", 32'(rt1), 32'd5);

    // load-use with one bubble
    drv(1'b1, 6'h00, 5'd5, 5'd1);
    #1 chk("lu1_stall", 32'(stall1), 32'h1);
    tick();
    chk("lu1_bubble", 32'(ctrl1), 32'h0);
    chk("lu1_bubble_rt", 32'(rt1), 32'h0);
    #1 chk("lu1_stall_off", 32'(stall1), 32'h0);
    tick();
    chk("lu1_add", 32'(ctrl1), 32'h4002);
    chk("lu1_add_rt", 32'(rt1), 32'd1);

    // decode table (rt=0 keeps loads hazard-free)
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, t_op[i], 5'd0, 5'd0);
      tick();
      chk($sformatf("dec_%0h", t_op[i]), 32'(ctrl1), 32'(t_exp[i]));
      chk($sformatf("dec_ill_%0h", t_op[i]), 32'(ill1), 32'h0);
    end
    drv(1'b0, 6'h3F, 5'd0, 5'd0);
    tick();
    chk("invalid_ctrl", 32'(ctrl1), 32'h0);
    chk("invalid_ill", 32'(ill1), 32'h0);

    rst = 1'b1; tick(); rst = 1'b0;

    // load-use with three bubbles
    drv(1'b1, 6'h23, 5'd0, 5'd7);
    tick();
    chk("lu3_lw", 32'(ctrl3), 32'h0903);
    drv(1'b1, 6'h2B, 5'd2, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("lu3_stall%0d", i), 32'(stall3), 32'h1);
      tick();
      chk($sformatf("lu3_bubble%0d", i), 32'(ctrl3), 32'h0);
    end
    #1 chk("lu3_stall_off", 32'(stall3), 32'h0);
    tick();
    chk("lu3_sw", 32'(ctrl3), 32'h0880);
    chk("lu3_sw_rt", 32'(rt3), 32'd7);

    // no hazard cases
    drv(1'b1, 6'h23, 5'd1, 5'd0);
    tick();
    chk("r0_lw", 32'(ctrl1), 32'h0903);
    drv(1'b1, 6'h00, 5'd0, 5'd0);
    #1 chk("r0_stall", 32'(stall1), 32'h0);
    tick();
    chk("r0_add", 32'(ctrl1), 32'h4002);
    drv(1'b1, 6'h23, 5'd0, 5'd4);
    tick();
    drv(1'b1, 6'h08, 5'd1, 5'd4);
    #1 chk("dest_stall", 32'(stall1), 32'h0);
    tick();
    chk("dest_addi", 32'(ctrl1), 32'h3802);
    chk("dest_addi_rt", 32'(rt1), 32'd4);

    // flush beats hazard
    drv(1'b1, 6'h23, 5'd0, 5'd6);
    tick();
    drv(1'b1, 6'h00, 5'd6, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ctrl", 32'(ctrl1), 32'h0);
    chk("fl_rt", 32'(rt1), 32'h0);
    #1 chk("fl_stall1", 32'(stall1), 32'h0);
    chk("fl_stall3", 32'(stall3), 32'h0);
    tick();
    chk("fl_add", 32'(ctrl1), 32'h4002);
    chk("fl_add3", 32'(ctrl3), 32'h4002);

    // illegal opcode pulse, held through a freeze
    drv(1'b1, 6'h3F, 5'd0, 5'd0);
    tick();
    chk("ill_ctrl", 32'(ctrl1), 32'h0);
    chk("ill_pulse", 32'(ill1), 32'h1);
    en = 1'b0;
    drv(1'b1, 6'h00, 5'd0, 5'd2);
    tick();
    chk("ill_hold", 32'(ill1), 32'h1);
    chk("ill_hold_ctrl", 32'(ctrl1), 32'h0);
    en = 1'b1;
    tick();
    chk("ill_clear", 32'(ill1), 32'h0);
    chk("ill_next", 32'(ctrl1), 32'h4002);
    en = 1'b0;
    drv(1'b1, 6'h2B, 5'd0, 5'd0);
    tick();
    chk("frz_ctrl", 32'(ctrl1), 32'h4002);
    chk("frz_rt", 32'(rt1), 32'd2);
    en = 1'b1;

    // freeze mid-stall, then reset
    drv(1'b1, 6'h23, 5'd0, 5'd3);
    tick();
    drv(1'b1, 6'h00, 5'd3, 5'd1);
    tick();
    chk("ms_enter", 32'(stall3), 32'h1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("ms_frz_stall%0d", i), 32'(stall3), 32'h1);
      chk($sformatf("ms_frz_ctrl%0d", i), 32'(ctrl3), 32'h0);
    end
    en = 1'b1;
    tick();
    chk("ms_resume_stall", 32'(stall3), 32'h1);
    rst = 1'b1;
    tick();
    chk("ms_rst_stall", 32'(stall3), 32'h0);
    chk("ms_rst_ctrl", 32'(ctrl3), 32'h0);
    chk("ms_rst_rt", 32'(rt3), 32'h0);
    chk("ms_rst_ill", 32'(ill3), 32'h0);
    rst = 1'b0;
    #1 chk("ms_after_stall", 32'(stall3), 32'h0);
    tick();
    chk("ms_after_add", 32'(ctrl3), 32'h4002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
